// File: rtl/burst_arb_pkg.sv
// Shared types and helpers for the burst arbiter.
package burst_arb_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_e;

  localparam int unsigned MAX_N = 16;

  // OR-reduction encoder; only meaningful for onehot0 input.
  function automatic logic [3:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/lru_mtx.sv
// Least-recently-granted priority matrix: w[i][j]=1 means requester i beats j.
module lru_mtx #(
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 upd,
  input  logic [$clog2(N)-1:0] upd_idx,
  output logic [N-1:0]         winner
);

  logic [N-1:0][N-1:0] w_q, w_d;
  logic [N-1:0]        blocked;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          w_q[i][j] <= (i < j);
        end
      end
    end else begin
      w_q <= w_d;
    end
  end

  // Released owner drops to lowest priority.
  always_comb begin
    w_d = w_q;
    if (upd) begin
      for (int k = 0; k < N; k++) begin
        if (k != int'(upd_idx)) begin
          w_d[upd_idx][k] = 1'b0;
          w_d[k][upd_idx] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    blocked = '0;
    winner  = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (j != i && req[j] && w_q[j][i]) blocked[i] = 1'b1;
      end
      winner[i] = req[i] & ~blocked[i];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = i + 1; j < N; j++) begin : g_col
      assert property (@(posedge clk) disable iff (rst) w_q[i][j] != w_q[j][i]);
    end
  end

endmodule

// File: rtl/burst_arb_ctrl.sv
// Burst-granular LRU arbiter for one shared valid/ready channel, with stall watchdog.
module burst_arb_ctrl
  import burst_arb_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  input  logic [N-1:0]         req_last,
  output logic [N-1:0]         req_ready,
  output logic                 dn_valid,
  output logic                 dn_last,
  input  logic                 dn_ready,
  output logic [$clog2(N)-1:0] sel,
  output logic                 busy,
  output logic                 err_tmo
);

  localparam int unsigned IDW = $clog2(N);
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  arb_state_e       state_q, state_d;
  logic [IDW-1:0]   sel_q, sel_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic [N-1:0]     winner;
  logic [MAX_N-1:0] win_ext;
  logic [IDW-1:0]   winner_idx;
  logic             xfer, last_xfer, tmo, rel;

  lru_mtx #(
    .N (N)
  ) u_lru_mtx (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .upd     (rel),
    .upd_idx (sel_q),
    .winner  (winner)
  );

  always_comb begin
    win_ext         = '0;
    win_ext[N-1:0]  = winner;
    winner_idx      = IDW'(onehot_to_idx(win_ext));
  end

  assign busy      = (state_q == BUSY);
  assign xfer      = busy & req_valid[sel_q] & dn_ready;
  assign last_xfer = xfer & req_last[sel_q];
  // A last beat landing on the timeout cycle wins over the watchdog.
  assign tmo       = busy & (wd_q == WDW'(TIMEOUT - 1)) & ~last_xfer;
  assign rel       = last_xfer | tmo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    wd_d    = wd_q;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d = BUSY;
          sel_d   = winner_idx;
          wd_d    = '0;
        end
      end
      BUSY: begin
        if (wd_q != WDW'(TIMEOUT)) wd_d = wd_q + 1'b1;
        if (rel) state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (busy) req_ready[sel_q] = dn_ready;
  end

  assign dn_valid = busy & req_valid[sel_q];
  assign dn_last  = busy & req_last[sel_q];
  assign sel      = sel_q;
  assign err_tmo  = tmo;

  assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  assert property (@(posedge clk) disable iff (rst) (busy && !rel) |=> (sel == $past(sel)));

endmodule

// File: tb/tb_burst_arb_ctrl.sv
// Directed self-checking bench for burst_arb_ctrl (N=4, TIMEOUT=8).
module tb_burst_arb_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_valid, req_last, req_ready;
  logic       dn_valid, dn_last, dn_ready, busy, err_tmo;
  logic [1:0] sel;

  int n_cmp = 0;
  int n_err = 0;

  burst_arb_ctrl #(
    .N       (4),
    .TIMEOUT (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_ready (req_ready),
    .dn_valid  (dn_valid),
    .dn_last   (dn_last),
    .dn_ready  (dn_ready),
    .sel       (sel),
    .busy      (busy),
    .err_tmo   (err_tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    int         exp_g [5];
    logic [3:0] exp_rdy;
    logic       v4 [7];
    logic       l4 [7];
    logic       r4 [7];
    int         beats;

    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    dn_ready  = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_dn_valid", dn_valid, 0);
    chk("rst_sel", sel, 0);
    chk("rst_err", err_tmo, 0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;

    // T1: reset priority order with all single-beat requesters
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    dn_ready  = 1'b1;
    settle();
    chk("t1_post_rst_ready", req_ready, 0);
    exp_g = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      chk("t1_idle_busy", busy, 0);
      tick();
      settle();
      exp_rdy = 4'b0001 << exp_g[k];
      chk("t1_busy", busy, 1);
      chk("t1_sel", sel, exp_g[k]);
      chk("t1_ready", req_ready, exp_rdy);
      chk("t1_dn_last", dn_last, 1);
      tick();
      settle();
    end
    req_valid = '0;
    req_last  = '0;
    settle();

    // T2: req2 holds the lock for 4 beats while req0 waits; order is now 1,2,3,0
    req_valid = 4'b0101;
    settle();
    chk("t2_idle", busy, 0);
    tick();
    for (int b = 1; b <= 4; b++) begin
      if (b == 4) req_last = 4'b0100;
      settle();
      chk("t2_sel", sel, 2);
      chk("t2_ready", req_ready, 4'b0100);
      chk("t2_dn_last", dn_last, (b == 4) ? 1 : 0);
      tick();
    end
    req_valid = 4'b0001;
    req_last  = 4'b0001;
    settle();
    chk("t2_bubble", busy, 0);
    tick();
    settle();
    chk("t2_next_sel", sel, 0);
    chk("t2_next_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    req_last  = '0;
    settle();
    chk("t2_done", busy, 0);

    // T3: req1/req3 two-beat bursts alternate; order is now 1,3,2,0
    req_valid = 4'b1010;
    settle();
    for (int b = 0; b < 4; b++) begin
      chk("t3_gap", busy, 0);
      tick();
      settle();
      chk("t3_sel_b1", sel, (b % 2) ? 3 : 1);
      chk("t3_last_b1", dn_last, 0);
      tick();
      req_last = 4'b1010;
      settle();
      chk("t3_sel_b2", sel, (b % 2) ? 3 : 1);
      chk("t3_last_b2", dn_last, 1);
      tick();
      req_last = '0;
      settle();
    end
    req_valid = '0;
    settle();

    // T4: backpressure and a 3-cycle valid gap on owner req2; req0 stays valid
    v4 = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    l4 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    r4 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    beats     = 0;
    req_valid = 4'b0101;
    dn_ready  = 1'b1;
    settle();
    tick();
    for (int c = 0; c < 7; c++) begin
      req_valid = {1'b0, v4[c], 1'b0, 1'b1};
      req_last  = {1'b0, l4[c], 2'b00};
      dn_ready  = r4[c];
      settle();
      chk("t4_busy", busy, 1);
      chk("t4_sel", sel, 2);
      chk("t4_dn_valid", dn_valid, v4[c]);
      chk("t4_ready", req_ready, r4[c] ? 4'b0100 : 4'b0000);
      if (req_ready[2] && req_valid[2]) beats++;
      tick();
    end
    req_valid = '0;
    req_last  = '0;
    dn_ready  = 1'b1;
    settle();
    chk("t4_beats", beats, 3);
    chk("t4_release", busy, 0);

    // T5: req0 stalls; watchdog fires on the 8th BUSY cycle; order is now 0,1,3,2
    req_valid = 4'b0001;
    dn_ready  = 1'b0;
    settle();
    tick();
    for (int c = 1; c <= 8; c++) begin
      settle();
      chk("t5_busy", busy, 1);
      chk("t5_err", err_tmo, (c == 8) ? 1 : 0);
      tick();
    end
    settle();
    chk("t5_idle", busy, 0);
    chk("t5_err_clear", err_tmo, 0);
    req_valid = 4'b1001;
    req_last  = 4'b1001;
    dn_ready  = 1'b1;
    settle();
    tick();
    settle();
    chk("t5_lowest", sel, 3);
    tick();
    req_valid = 4'b0010;
    req_last  = '0;
    dn_ready  = 1'b0;
    settle();
    chk("t5_idle2", busy, 0);
    tick();
    // Corner: last beat on the timeout cycle is a clean completion
    for (int c = 1; c <= 8; c++) begin
      if (c == 8) begin
        dn_ready = 1'b1;
        req_last = 4'b0010;
      end
      settle();
      chk("t5c_sel", sel, 1);
      chk("t5c_err", err_tmo, 0);
      tick();
    end
    req_valid = '0;
    req_last  = '0;
    settle();
    chk("t5c_idle", busy, 0);

    // T6: async reset during beat 2 of a req2 burst; order is now 2,0,3,1
    req_valid = 4'b0100;
    dn_ready  = 1'b1;
    settle();
    tick();
    settle();
    chk("t6_sel", sel, 2);
    tick();
    settle();
    chk("t6_beat2", busy, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ready", req_ready, 0);
    chk("t6_rst_dn_valid", dn_valid, 0);
    chk("t6_rst_sel", sel, 0);
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    tick();
    chk("t6_held", busy, 0);
    rst = 1'b0;
    settle();
    tick();
    settle();
    chk("t6_after_busy", busy, 1);
    chk("t6_after_sel", sel, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
